aes_round_ctrl: RTL and testbench

- Sequences the AES-128 encryption datapath: sub-bytes, shift-rows, mix-columns and add-round-key.
- Owns the 128-bit cipher state register.
- Presents the state register to the combinational step units and captures the output of whichever step is active.
- Fetches round keys from the key-expansion block over a request/valid handshake.
- Reports completion to the top-level controller with a start/busy/done handshake.

---
 rtl/aes_round_ctrl.sv | 105 ++++++++++
 tb/tb_aes_round_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: owns the cipher state register and walks the
// KEY/SUB/SHIFT/MIX steps, fetching round keys over a req/valid handshake.
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] plaintext,
  output logic         busy,
  output logic         done,
  output logic [127:0] ciphertext,
  output logic [127:0] state_reg,
  output logic         sbox_enable,
  output logic         srows_enable,
  output logic         mcol_enable,
  input  logic [127:0] sbox_data,
  input  logic [127:0] srows_data,
  input  logic [127:0] mcol_data,
  output logic         rkey_req,
  input  logic         rkey_valid,
  input  logic [127:0] rkey,
  output logic [3:0]   round_num
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    SUB,
    SHIFT,
    MIX,
    DONE
  } fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] data_q, data_d;
  logic [3:0]   round_q, round_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= IDLE;
      data_q  <= '0;
      round_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    data_d  = data_q;
    round_d = round_q;
    case (fsm_q)
      IDLE, DONE: begin
        // DONE accepts start just like IDLE so blocks can run back to back
        if (start) begin
          data_d  = plaintext;
          round_d = '0;
          fsm_d   = KEY;
        end else begin
          fsm_d = IDLE;
        end
      end
      KEY: begin
        if (rkey_valid) begin
          data_d = data_q ^ rkey;
          if (round_q == LAST_ROUND) begin
            fsm_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            fsm_d   = SUB;
          end
        end
      end
      SUB: begin
        data_d = sbox_data;
        fsm_d  = SHIFT;
      end
      SHIFT: begin
        data_d = srows_data;
        fsm_d  = (round_q == LAST_ROUND) ? KEY : MIX;
      end
      MIX: begin
        data_d = mcol_data;
        fsm_d  = KEY;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign busy         = (fsm_q != IDLE) && (fsm_q != DONE);
  assign done         = (fsm_q == DONE);
  assign sbox_enable  = (fsm_q == SUB);
  assign srows_enable = (fsm_q == SHIFT);
  assign mcol_enable  = (fsm_q == MIX);
  assign rkey_req     = (fsm_q == KEY);
  assign state_reg    = data_q;
  assign ciphertext   = data_q;
  assign round_num    = round_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: a behavioural AES step/key model feeds the
// DUT, and results are compared against FIPS-197 known-answer vectors.
module tb_aes_round_ctrl;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [127:0] plaintext;
  logic         busy, done;
  logic [127:0] ciphertext, state_reg;
  logic         sbox_enable, srows_enable, mcol_enable;
  logic [127:0] sbox_data, srows_data, mcol_data;
  logic         rkey_req, rkey_valid;
  logic [127:0] rkey;
  logic [3:0]   round_num;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_t [256];
  logic [127:0] round_keys [16];

  logic         stall_en = 1'b0;
  int           stall_cnt = 0;
  logic         log_en = 1'b0;
  logic [3:0]   seq_q [$];
  int           onehot_bad = 0;
  int           mcol_cnt = 0;
  int           frozen_bad = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_state = '0;
  logic [3:0]   prev_round = '0;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .plaintext(plaintext),
    .busy(busy), .done(done), .ciphertext(ciphertext), .state_reg(state_reg),
    .sbox_enable(sbox_enable), .srows_enable(srows_enable), .mcol_enable(mcol_enable),
    .sbox_data(sbox_data), .srows_data(srows_data), .mcol_data(mcol_data),
    .rkey_req(rkey_req), .rkey_valid(rkey_valid), .rkey(rkey), .round_num(round_num)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = '0;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // byte i of a block sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[s[127-8*i -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) round_keys[r] = '0;
    for (int r = 0; r < 11; r++) round_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  assign sbox_data  = sub_bytes(state_reg);
  assign srows_data = shift_rows(state_reg);
  assign mcol_data  = mix_columns(state_reg);
  assign rkey       = round_keys[round_num];
  assign rkey_valid = !(stall_en && rkey_req && round_num == 4'd5 && stall_cnt < 3);

  always @(posedge clk) begin
    if (!stall_en) stall_cnt <= 0;
    else if (rkey_req && !rkey_valid) stall_cnt <= stall_cnt + 1;
  end

  always @(negedge clk) begin
    if (prev_stall && (state_reg !== prev_state || round_num !== prev_round)) frozen_bad++;
    prev_stall = rkey_req && !rkey_valid;
    prev_state = state_reg;
    prev_round = round_num;
    if (log_en && busy) begin
      seq_q.push_back({sbox_enable, srows_enable, mcol_enable, rkey_req});
      if ($countones({sbox_enable, srows_enable, mcol_enable, rkey_req}) > 1) onehot_bad++;
      if (mcol_enable) mcol_cnt++;
    end
  end

  // b2b: caller is sampling inside a DONE cycle, so start is driven right away
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp_ct,
                           input int exp_lat, input int glitch_at, input bit b2b);
    int cnt = 0;
    int busy_cnt = 0;
    bit seen = 1'b0;
    if (!b2b) @(negedge clk);
    plaintext = pt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    plaintext = ~pt;
    check({tag, "_busy_after_start"}, 128'(busy), 128'(1'b1));
    if (busy) busy_cnt++;
    while (cnt < 200 && !seen) begin
      @(posedge clk);
      cnt++;
      #1;
      start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
      if (cnt == glitch_at) begin
        start = 1'b1;
        plaintext = ~exp_ct;
      end
    end
    check({tag, "_done_seen"}, 128'(seen), 128'(1'b1));
    check({tag, "_latency"}, 128'(cnt), 128'(exp_lat));
    check({tag, "_busy_cycles"}, 128'(busy_cnt), 128'(exp_lat));
    check({tag, "_busy_in_done"}, 128'(busy), 128'(1'b0));
    check({tag, "_ciphertext"}, ciphertext, exp_ct);
  endtask

  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    logic [3:0] exp_seq [$];
    int seq_bad;
    int done_cnt;
    bit reached;

    n_rst = 1'b0;
    start = 1'b0;
    plaintext = '0;
    build_sbox();
    expand_key(KEY_B);

    #12;
    check("reset_ctrl", 128'({busy, done, sbox_enable, srows_enable, mcol_enable, rkey_req}), '0);
    check("reset_state", state_reg, '0);
    check("reset_round", 128'(round_num), '0);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ctrl", 128'({busy, done, rkey_req}), '0);

    // known-answer vector with full enable log
    log_en = 1'b1;
    run_block("fips_b", PT_B, CT_B, 40, -1, 1'b0);
    log_en = 1'b0;
    exp_seq.push_back(4'b0001);
    for (int r = 1; r < 10; r++) begin
      exp_seq.push_back(4'b1000);
      exp_seq.push_back(4'b0100);
      exp_seq.push_back(4'b0010);
      exp_seq.push_back(4'b0001);
    end
    exp_seq.push_back(4'b1000);
    exp_seq.push_back(4'b0100);
    exp_seq.push_back(4'b0001);
    check("seq_len", 128'(seq_q.size()), 128'(exp_seq.size()));
    seq_bad = 0;
    for (int i = 0; i < exp_seq.size() && i < seq_q.size(); i++)
      if (seq_q[i] !== exp_seq[i]) seq_bad++;
    check("seq_pattern_errors", 128'(seq_bad), '0);
    check("enable_onehot_errors", 128'(onehot_bad), '0);
    check("mcol_count", 128'(mcol_cnt), 128'(9));
    @(posedge clk);
    #1;
    check("done_single_cycle", 128'(done), '0);
    check("idle_after_done", 128'(busy), '0);
    check("ct_held_in_idle", ciphertext, CT_B);

    // round-5 key stall of three cycles
    stall_en = 1'b1;
    run_block("stall", PT_B, CT_B, 43, -1, 1'b0);
    check("stall_cycles", 128'(stall_cnt), 128'(3));
    check("stall_frozen_errors", 128'(frozen_bad), '0);
    stall_en = 1'b0;

    // start pulsed mid-run must be ignored
    run_block("glitch", PT_B, CT_B, 40, 7, 1'b0);

    // back-to-back: start in the DONE cycle with a new key and plaintext
    expand_key(KEY_C);
    run_block("b2b", PT_C, CT_C, 40, -1, 1'b1);

    // asynchronous reset in round 6
    expand_key(KEY_B);
    @(negedge clk);
    plaintext = PT_B;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      @(negedge clk);
      if (round_num == 4'd6) reached = 1'b1;
    end
    check("reached_round6", 128'(reached), 128'(1'b1));
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("async_rst_ctrl", 128'({busy, done, sbox_enable, srows_enable, mcol_enable, rkey_req}), '0);
    check("async_rst_state", state_reg, '0);
    check("async_rst_round", 128'(round_num), '0);
    #12;
    n_rst = 1'b1;
    done_cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("no_done_after_rst", 128'(done_cnt), '0);
    check("idle_after_rst", 128'(busy), '0);
    check("state_after_rst", state_reg, '0);

    run_block("post_rst", PT_B, CT_B, 40, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
